// File: rtl/barrel_pkg.sv
// Shared definitions for the pipelined barrel shifter/rotator.
// The mode encoding doubles as the s1/s0 select of each stage's per-bit 4:1 mux.
package barrel_pkg;

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROR = 2'b11
    } mode_t;

endpackage

// File: rtl/barrel_stage.sv
// One shift level of the barrel pipeline: conditionally shifts by SHIFT when its amt bit is set,
// then registers the result together with amt, mode and the carried sign bit.
module barrel_stage
    import barrel_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHIFT = 1,
    localparam int LOG2W = $clog2(WIDTH),
    localparam int BIT = $clog2(SHIFT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LOG2W-1:0] in_amt,
    input  logic [1:0]       in_mode,
    input  logic             in_sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [LOG2W-1:0] out_amt,
    output logic [1:0]       out_mode,
    output logic             out_sign
);

    mode_t            mode_sel;
    mode_t            mode_q;
    logic [WIDTH-1:0] sll;
    logic [WIDTH-1:0] srl;
    logic [WIDTH-1:0] sra;
    logic [WIDTH-1:0] ror;
    logic [WIDTH-1:0] shifted;

    assign mode_sel = mode_t'(in_mode);

    // SRA fills from the sign of the original word, not from this stage's MSB.
    assign sll = {in_data[WIDTH-SHIFT-1:0], {SHIFT{1'b0}}};
    assign srl = {{SHIFT{1'b0}}, in_data[WIDTH-1:SHIFT]};
    assign sra = {{SHIFT{in_sign}}, in_data[WIDTH-1:SHIFT]};
    assign ror = {in_data[SHIFT-1:0], in_data[WIDTH-1:SHIFT]};

    always_comb begin
        shifted = in_data;
        if (in_amt[BIT]) begin
            case (mode_sel)
                MODE_SLL: shifted = sll;
                MODE_SRL: shifted = srl;
                MODE_SRA: shifted = sra;
                MODE_ROR: shifted = ror;
            endcase
        end
    end

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_amt   <= '0;
            mode_q    <= MODE_SLL;
            out_sign  <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= shifted;
                out_amt  <= in_amt;
                mode_q   <= mode_sel;
                out_sign <= in_sign;
            end
        end
    end

    assign out_mode = mode_q;

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter/rotator: LOG2W chained barrel_stage instances, shift by 2^k at stage k,
// with a combinational ready chain so a full pipeline accepts and emits on the same edge.
module barrel_shift_pipe
    import barrel_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int LOG2W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LOG2W-1:0] in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    for (genvar k = 0; k < LOG2W; k++) begin : g_stage
        logic             prev_valid;
        logic [WIDTH-1:0] prev_data;
        logic [LOG2W-1:0] prev_amt;
        logic [1:0]       prev_mode;
        logic             prev_sign;
        logic             next_ready;
        logic             ready;
        logic             valid;
        logic [WIDTH-1:0] data;
        logic [LOG2W-1:0] amt;
        logic [1:0]       mode;
        logic             sign;

        if (k == 0) begin : g_head
            assign prev_valid = in_valid;
            assign prev_data  = in_data;
            assign prev_amt   = in_amt;
            assign prev_mode  = in_mode;
            assign prev_sign  = in_data[WIDTH-1];
        end else begin : g_link
            assign prev_valid = g_stage[k-1].valid;
            assign prev_data  = g_stage[k-1].data;
            assign prev_amt   = g_stage[k-1].amt;
            assign prev_mode  = g_stage[k-1].mode;
            assign prev_sign  = g_stage[k-1].sign;
        end

        if (k == LOG2W - 1) begin : g_tail
            assign next_ready = out_ready;
        end else begin : g_next
            assign next_ready = g_stage[k+1].ready;
        end

        barrel_stage #(
            .WIDTH(WIDTH),
            .SHIFT(1 << k)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (prev_valid),
            .in_ready (ready),
            .in_data  (prev_data),
            .in_amt   (prev_amt),
            .in_mode  (prev_mode),
            .in_sign  (prev_sign),
            .out_valid(valid),
            .out_ready(next_ready),
            .out_data (data),
            .out_amt  (amt),
            .out_mode (mode),
            .out_sign (sign)
        );
    end

    // Stage registers already read 0 during reset; the gate also holds off the producer.
    assign in_ready  = rst_n && g_stage[0].ready;
    assign out_valid = g_stage[LOG2W-1].valid;
    assign out_data  = g_stage[LOG2W-1].data;

    // Control fields of the final stage have no consumer past the output.
    logic tail_unused;
    assign tail_unused = ^{g_stage[LOG2W-1].amt, g_stage[LOG2W-1].mode, g_stage[LOG2W-1].sign};

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Self-checking bench for barrel_shift_pipe: directed and random traffic against a shift/rotate
// reference model, plus backpressure, mid-flight reset and a WIDTH sweep.
module tb_barrel_shift_pipe;

    localparam int W  = 8;
    localparam int LW = 3;

    typedef struct {
        logic [31:0] exp;
        int          cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [LW-1:0] in_amt;
    logic [1:0]   in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_count = 0;
    int out_count = 0;
    logic lat_strict;
    logic drv_has_exp;
    logic [W-1:0] drv_exp;
    logic hold_prev = 1'b0;
    logic [W-1:0] prev_data;
    logic [2:0] sweep_done = '0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    barrel_shift_pipe #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_amt   (in_amt),
        .in_mode  (in_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain shift/rotate arithmetic on a w-bit value held in 32 bits.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int amt, input int mode,
                                              input int w);
        logic [31:0] mask;
        logic [31:0] r;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case (mode)
            0: r = d << amt;
            1: r = d >> amt;
            2: r = (d >> amt) | (d[w-1] ? (~(mask >> amt)) : 32'd0);
            default: r = (d >> amt) | (d << (w - amt));
        endcase
        return r & mask;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) begin
                q.push_back('{drv_has_exp ? 32'(drv_exp)
                                          : ref_shift(32'(in_data), int'(in_amt), int'(in_mode), W),
                              cyc});
                acc_count++;
            end
            if (out_valid && out_ready) begin
                out_count++;
                if (q.size() == 0) begin
                    check("out_when_empty", 32'(out_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("data", 32'(out_data), e.exp);
                    if (lat_strict) check("latency", 32'(cyc - e.cyc), 32'(LW));
                end
            end
            if (hold_prev) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(prev_data));
            end
            hold_prev = out_valid && !out_ready;
            prev_data = out_data;
        end else begin
            hold_prev = 1'b0;
        end
    end

    // Called right after a posedge (+#1); returns at the same phase after the word is taken.
    task automatic send(input logic [W-1:0] d, input logic [LW-1:0] a, input logic [1:0] m,
                        input logic has_exp, input logic [W-1:0] exp);
        int n;
        in_valid = 1'b1;
        in_data = d;
        in_amt = a;
        in_mode = m;
        drv_has_exp = has_exp;
        drv_exp = exp;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("drain_empty", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] exp96 [4];

    initial begin
        int a0;
        int c0;
        int o0;
        int n;
        exp96 = '{8'hB0, 8'h12, 8'hF2, 8'hD2};
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_amt = '0;
        in_mode = '0;
        out_ready = 1'b1;
        drv_has_exp = 1'b0;
        drv_exp = '0;
        lat_strict = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        for (int m = 0; m < 4; m++) send(8'h96, 3'd3, 2'(m), 1'b1, exp96[m]);
        for (int m = 0; m < 4; m++) send(8'hA5, 3'd0, 2'(m), 1'b1, 8'hA5);
        send(8'h80, 3'd7, 2'b10, 1'b1, 8'hFF);
        send(8'h01, 3'd7, 2'b11, 1'b1, 8'h02);
        drain();

        c0 = cyc;
        o0 = out_count;
        for (int i = 0; i < 16; i++)
            send(8'($urandom), 3'($urandom), 2'($urandom), 1'b0, '0);
        check("stream_cycles", 32'(cyc - c0), 32'd16);
        drain();
        check("stream_outputs", 32'(out_count - o0), 32'd16);

        lat_strict = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        a0 = acc_count;
        for (int i = 0; i < 6; i++) begin
            in_data = 8'($urandom);
            in_amt = 3'($urandom);
            in_mode = 2'($urandom);
            @(posedge clk);
            #1;
        end
        check("stall_accepts", 32'(acc_count - a0), 32'd3);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        for (int i = 0; i < 150; i++) begin
            in_valid = 1'($urandom);
            in_data = 8'($urandom);
            in_amt = 3'($urandom);
            in_mode = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        lat_strict = 1'b1;

        o0 = out_count;
        in_valid = 1'b1;
        in_data = 8'hFF;
        in_amt = 3'd0;
        in_mode = 2'b00;
        @(posedge clk);
        #1;
        in_data = 8'h3C;
        in_amt = 3'd1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        q.delete();
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_data", 32'(out_data), 32'd0);
        check("async_rst_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("in_reset_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("release_ready", 32'(in_ready), 32'd1);
        repeat (10) @(posedge clk);
        check("no_ghost_outputs", 32'(out_count - o0), 32'd0);

        n = 0;
        while (sweep_done != 3'b111 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check("sweep_done", 32'(sweep_done), 32'd7);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int SW = (g == 0) ? 2 : ((g == 1) ? 16 : 32);
        localparam int SL = $clog2(SW);

        logic          s_rst_n;
        logic          s_in_valid;
        logic          s_in_ready;
        logic [SW-1:0] s_in_data;
        logic [SL-1:0] s_in_amt;
        logic [1:0]    s_in_mode;
        logic          s_out_valid;
        logic          s_out_ready;
        logic [SW-1:0] s_out_data;
        exp_t          sq[$];

        barrel_shift_pipe #(.WIDTH(SW)) dut_sweep (
            .clk      (clk),
            .rst_n    (s_rst_n),
            .in_valid (s_in_valid),
            .in_ready (s_in_ready),
            .in_data  (s_in_data),
            .in_amt   (s_in_amt),
            .in_mode  (s_in_mode),
            .out_valid(s_out_valid),
            .out_ready(s_out_ready),
            .out_data (s_out_data)
        );

        always @(negedge clk) begin
            if (s_rst_n) begin
                if (s_in_valid && s_in_ready)
                    sq.push_back('{ref_shift(32'(s_in_data), int'(s_in_amt), int'(s_in_mode), SW),
                                   cyc});
                if (s_out_valid && s_out_ready) begin
                    if (sq.size() == 0) begin
                        check($sformatf("w%0d_out_when_empty", SW), 32'(s_out_valid), 32'd0);
                    end else begin
                        exp_t e;
                        e = sq.pop_front();
                        check($sformatf("w%0d_data", SW), 32'(s_out_data), e.exp);
                        check($sformatf("w%0d_latency", SW), 32'(cyc - e.cyc), 32'(SL));
                    end
                end
            end
        end

        initial begin
            int n;
            s_rst_n = 1'b0;
            s_in_valid = 1'b0;
            s_in_data = '0;
            s_in_amt = '0;
            s_in_mode = '0;
            s_out_ready = 1'b1;
            #1;
            check($sformatf("w%0d_rst_ready", SW), 32'(s_in_ready), 32'd0);
            repeat (2) @(posedge clk);
            #2 s_rst_n = 1'b1;
            @(posedge clk);
            #1;
            for (int i = 0; i < 80; i++) begin
                s_in_valid = 1'($urandom);
                s_in_data = SW'($urandom);
                s_in_amt = SL'($urandom);
                s_in_mode = 2'($urandom);
                @(posedge clk);
                #1;
            end
            s_in_valid = 1'b0;
            n = 0;
            while (sq.size() != 0 && n < 100) begin
                @(posedge clk);
                n++;
            end
            check($sformatf("w%0d_drain", SW), 32'(sq.size()), 32'd0);
            sweep_done[g] = 1'b1;
        end
    end

endmodule
